// File: rtl/biquad_mac_seq.sv
// biquad_mac_seq
//   Time-shares one external MAC across NSEC cascaded direct-form-I biquad
//   sections. Every accepted sample runs through each section:
//   CLR(1) MAC(5) DRAIN(1) WB(1). The last WB registers the output sample
//   and returns to IDLE, so the output pulse coincides with ready again.
//
// Ports
//   ic_clk, ic_rst_n          clock, async active-low reset
//   id_din/ic_din_valid       input sample + valid
//   oc_din_ready              high in IDLE only
//   ic_clr_state              zero all section history (IDLE only)
//   od_dout/oc_dout_valid     filtered sample, one-cycle valid pulse
//   oc_busy                   state != IDLE
//   oc_mac_rst/ce/add         MAC control, one cycle ahead of its operand
//   od_mac_din/oc_coef_addr   MAC data operand / coefficient ROM address
//   id_mac_acc                MAC accumulator readback
module biquad_mac_seq #(
  parameter int Win  = 24,
  parameter int Wc   = 27,
  parameter int Wacc = 64,
  parameter int NSEC = 4,
  parameter int FRAC = 25,
  parameter int CAW  = $clog2(NSEC*5)
) (
  input  logic            ic_clk,
  input  logic            ic_rst_n,
  input  logic [Win-1:0]  id_din,
  input  logic            ic_din_valid,
  output logic            oc_din_ready,
  input  logic            ic_clr_state,
  output logic [Win-1:0]  od_dout,
  output logic            oc_dout_valid,
  output logic            oc_busy,
  output logic            oc_mac_rst,
  output logic            oc_mac_ce,
  output logic            oc_mac_add,
  output logic [Win-1:0]  od_mac_din,
  output logic [CAW-1:0]  oc_coef_addr,
  input  logic [Wacc-1:0] id_mac_acc
);

  localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;

  // Coefficient x data product must fit the accumulator.
  if (NSEC < 1 || NSEC > 16 || Wc + Win > Wacc) begin : g_param_chk
    $error("biquad_mac_seq: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_DRAIN, S_WB} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_term;        // MAC cycle index 0..4
  logic [SW-1:0]       r_sec;
  logic signed [Win-1:0] r_x;         // input of the section being computed
  logic signed [Win-1:0] r_x1 [NSEC];
  logic signed [Win-1:0] r_x2 [NSEC];
  logic signed [Win-1:0] r_y1 [NSEC];
  logic signed [Win-1:0] r_y2 [NSEC];
  logic signed [Win-1:0] r_dout;
  logic                  r_dout_valid;

  logic                  w_last_sec;
  logic                  w_op_act;
  logic [2:0]            w_op_term;
  logic signed [Win-1:0] w_op;
  logic signed [Wacc-1:0] w_shift;
  logic signed [Win-1:0]  w_y;

  localparam logic signed [Wacc-1:0] SAT_MAX = {{(Wacc-Win+1){1'b0}}, {(Win-1){1'b1}}};
  localparam logic signed [Wacc-1:0] SAT_MIN = {{(Wacc-Win+1){1'b1}}, {(Win-1){1'b0}}};

  assign w_last_sec   = (r_sec == SW'(NSEC-1));
  assign oc_din_ready = (r_state == S_IDLE);
  assign oc_busy      = (r_state != S_IDLE);
  assign od_dout      = r_dout;
  assign oc_dout_valid = r_dout_valid;

  // Quantize: arithmetic shift then clamp to the sample range.
  assign w_shift = $signed(id_mac_acc) >>> FRAC;
  assign w_y = (w_shift > SAT_MAX) ? SAT_MAX[Win-1:0] :
               (w_shift < SAT_MIN) ? SAT_MIN[Win-1:0] : w_shift[Win-1:0];

  // ---------------- FSM ----------------
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ic_din_valid) w_next = S_CLR;
      S_CLR:   w_next = S_MAC;
      S_MAC:   if (r_term == 3'd4) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WB;
      S_WB:    w_next = w_last_sec ? S_IDLE : S_CLR;
      default: w_next = S_IDLE;
    endcase
  end

  // MAC control is issued in MAC cycle t; operand/address for term t follow
  // one cycle later (MAC cycles 1..4, then DRAIN carries term 4).
  always_comb begin
    oc_mac_rst = 1'b0;
    oc_mac_ce  = 1'b0;
    oc_mac_add = 1'b1;
    w_op_act   = 1'b0;
    w_op_term  = 3'd0;
    case (r_state)
      S_CLR: oc_mac_rst = 1'b1;
      S_MAC: begin
        oc_mac_ce  = 1'b1;
        oc_mac_add = (r_term < 3'd3);
        if (r_term != 3'd0) begin
          w_op_act  = 1'b1;
          w_op_term = r_term - 3'd1;
        end
      end
      S_DRAIN: begin
        w_op_act  = 1'b1;
        w_op_term = 3'd4;
      end
      default: ;
    endcase
    // Hold the MAC cleared while the sequencer itself is in reset.
    if (!ic_rst_n) oc_mac_rst = 1'b1;
  end

  always_comb begin
    case (w_op_term)
      3'd0:    w_op = r_x;
      3'd1:    w_op = r_x1[r_sec];
      3'd2:    w_op = r_x2[r_sec];
      3'd3:    w_op = r_y1[r_sec];
      default: w_op = r_y2[r_sec];
    endcase
    od_mac_din   = '0;
    oc_coef_addr = '0;
    if (w_op_act) begin
      od_mac_din   = w_op;
      oc_coef_addr = CAW'(r_sec) * CAW'(5) + CAW'(w_op_term);
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      r_term       <= '0;
      r_sec        <= '0;
      r_x          <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      for (int i = 0; i < NSEC; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Clearing happens on the accept edge too, so a coincident sample
          // starts from zero history.
          if (ic_clr_state) begin
            for (int i = 0; i < NSEC; i++) begin
              r_x1[i] <= '0;
              r_x2[i] <= '0;
              r_y1[i] <= '0;
              r_y2[i] <= '0;
            end
          end
          if (ic_din_valid) begin
            r_x   <= $signed(id_din);
            r_sec <= '0;
          end
        end
        S_CLR: r_term <= '0;
        S_MAC: r_term <= (r_term == 3'd4) ? 3'd0 : r_term + 3'd1;
        S_WB: begin
          r_x2[r_sec] <= r_x1[r_sec];
          r_x1[r_sec] <= r_x;
          r_y2[r_sec] <= r_y1[r_sec];
          r_y1[r_sec] <= w_y;
          r_x         <= w_y;
          if (w_last_sec) begin
            r_dout       <= w_y;
            r_dout_valid <= 1'b1;
            r_sec        <= '0;
          end else begin
            r_sec <= r_sec + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/biquad_mac_seq.md
Name: biquad_mac_seq

Overview:
- Sequencer that time-shares one external multiply-accumulate unit across a cascade of NSEC direct-form-I biquad sections; core of the EQ filter path.
- Per accepted audio sample, drives MAC control (clear/enable/add-sub), data operand and coefficient-ROM address for 5 products per section.
- Reads back the accumulator, quantizes/saturates it, updates section history, and chains the result into the next section. Emits one filtered sample per input sample.

Parameters:
- Win, 24, audio sample and MAC data-operand width (signed)
- Wc, 27, coefficient width (signed; informational, ROM is external)
- Wacc, 64, MAC accumulator width
- NSEC, 4, number of cascaded biquad sections (1..16)
- FRAC, 25, coefficient fractional bits (Q2.25); accumulator shift amount
- CAW, $clog2(NSEC*5), coefficient address width

Ports:
- ic_clk  in  1  clock
- ic_rst_n  in  1  asynchronous active-low reset
- id_din  in  Win  input sample, signed
- ic_din_valid  in  1  input sample valid
- oc_din_ready  out  1  ready to accept sample (high only in IDLE)
- ic_clr_state  in  1  clear all section history; honoured only in IDLE
- od_dout  out  Win  filtered sample, signed, registered
- oc_dout_valid  out  1  one-cycle pulse, od_dout valid
- oc_busy  out  1  high whenever state != IDLE
- oc_mac_rst  out  1  MAC accumulator clear request
- oc_mac_ce  out  1  MAC accumulate enable
- oc_mac_add  out  1  1 = acc + product, 0 = acc - product
- od_mac_din  out  Win  MAC data operand
- oc_coef_addr  out  CAW  coefficient ROM address = sec*5 + term; ROM read is combinational into MAC
- id_mac_acc  in  Wacc  MAC accumulator value

Behaviour:
- MAC contract: it registers rst/ce/add internally. Control for term t is therefore issued one cycle before od_mac_din and oc_coef_addr for term t. Accumulator result is readable two cycles after the last ce.
- Terms per section s: t0 = b0*x, t1 = b1*x1, t2 = b2*x2 (add); t3 = a1*y1, t4 = a2*y2 (subtract). x = section input, x1/x2 = past inputs, y1/y2 = past outputs.
- FSM: IDLE -> CLR (1 cycle) -> MAC (5 cycles) -> DRAIN (1) -> WB (1) -> CLR of next section, or OUT after section NSEC-1. OUT returns to IDLE.
  - CLR: oc_mac_rst=1.
  - MAC cycle t: oc_mac_ce=1; oc_mac_add=(t<3).
  - Operand/address for term t are presented in the cycle after MAC cycle t, i.e. MAC cycles 1..4 and DRAIN.
  - WB: sample id_mac_acc; y = sat_Win(id_mac_acc >>> FRAC), arithmetic shift, truncate. Then x2<=x1, x1<=x, y2<=y1, y1<=y for section s; next-section input register <= y.
  - OUT (last WB edge): od_dout<=y, oc_dout_valid=1 for one cycle.
- 8 cycles per section. Accept at edge of cycle a -> oc_dout_valid in cycle a+8*NSEC+1, with oc_din_ready high again in that same cycle.
- Outside their active cycles: oc_mac_ce=0, oc_mac_rst=0, oc_mac_add=1, od_mac_din=0, oc_coef_addr=0.
- Handshake: transfer when ic_din_valid & oc_din_ready. No output backpressure. ic_din_valid while busy is ignored, not queued.
- ic_clr_state in IDLE: all history zeroed next edge. If ic_clr_state and a valid sample coincide, clear first; the sample is processed with zero history in the same transfer.
- Saturation: y > 2^(Win-1)-1 -> 2^(Win-1)-1; y < -2^(Win-1) -> -2^(Win-1).
- Reset (async, any state incl. mid-sample): state=IDLE, history=0, od_dout=0, oc_dout_valid=0, oc_mac_ce=0, oc_mac_rst=1 (MAC cleared), oc_mac_add=1, od_mac_din=0, oc_coef_addr=0, oc_din_ready=1 after release. An in-flight sample is discarded with no output pulse.

Test Plan:
- NSEC=1, b0=2^25, rest 0; din=1000 -> dout=1000, oc_dout_valid exactly 9 cycles after accept; din=-5 -> -5.
- NSEC=1, b1=2^25 only; samples 100, 200, 300 -> outputs 0, 100, 200.
- NSEC=1, b0=2^25, a1=-2^24; impulse 1024 then zeros -> 1024, 512, 256, 128.
- Saturation: b0=2^26-1, din=0x7FFFFF -> 0x7FFFFF; din=-0x800000 -> -0x800000.
- Control timing, NSEC=2: per section 1 rst, 5 ce with add=1,1,1,0,0; addresses 0..4 then 5..9, each lagging its ce by 1 cycle; din during busy ignored.
- Assert ic_rst_n low in section 1 WB -> outputs at reset values, no dout pulse; the next sample sees zero history. ic_clr_state in IDLE zeroes history the same way.
